// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: request accepted in IDLE, response raised LATENCY edges later
// and held until resp_ready; no new request is taken while a transaction is pending. Memory survives reset.
module data_mem_responder #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WIDTH-1:0]     req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  output logic [WIDTH-1:0]     dbg_data
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 we_q;
  logic                 mis_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [WIDTH-1:0]     wdata_q;

  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_err_q;
  logic [WIDTH-1:0]     resp_rdata_q;

  logic [WIDTH-1:0]     mem [DEPTH];

  logic [ADDR_BITS-1:0] idx_d;
  logic                 mis_d;
  logic                 access;
  logic                 mem_wr;
  logic [WIDTH-ADDR_BITS-3:0] unused_addr_hi;

  // Upper address bits are deliberately dropped so indices wrap modulo DEPTH.
  assign idx_d          = req_addr[ADDR_BITS+1:2];
  assign mis_d          = |req_addr[1:0];
  assign unused_addr_hi = req_addr[WIDTH-1:ADDR_BITS+2];

  assign access = (state_q == WAIT) && (cnt_q == '0);
  assign mem_wr = rst && access && we_q && !mis_q;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            idx_q       <= idx_d;
            wdata_q     <= req_wdata;
            mis_q       <= mis_d;
            cnt_q       <= CNT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= mis_q;
            resp_rdata_q <= (!mis_q && !we_q) ? mem[idx_q] : '0;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_data   = mem[dbg_addr];

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus randomized traffic against a word-array model.
module tb_data_mem_responder;

  localparam int WIDTH     = 32;
  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 256;

  logic                 clk        = 1'b0;
  logic                 rst        = 1'b0;
  logic                 req_valid  = 1'b0;
  logic                 req_ready;
  logic                 req_we     = 1'b0;
  logic [WIDTH-1:0]     req_addr   = '0;
  logic [WIDTH-1:0]     req_wdata  = '0;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [WIDTH-1:0]     resp_rdata;
  logic                 resp_err;
  logic [ADDR_BITS-1:0] dbg_addr   = '0;
  logic [WIDTH-1:0]     dbg_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  data_mem_responder #(
    .WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Reference behaviour: misaligned -> error, aligned store updates the word, aligned load returns it.
  task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err);
    err = (addr % 4) != 0;
    rd  = 32'h0;
    if (!err) begin
      if (we) ref_mem[widx(addr)] = wd;
      else    rd = ref_mem[widx(addr)];
    end
  endtask

  // Drives one transaction; returns what it observed, comparisons are made by the callers.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input bit scramble,
                     output bit rdy, output int lat, output logic [31:0] rd,
                     output logic err, output bit stable);
    int n;
    @(negedge clk);
    rdy        = req_ready;
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wd;
    resp_ready = 1'b0;
    @(posedge clk);
    n   = 0;
    lat = -1;
    while (lat < 0 && n < 40) begin
      @(negedge clk);
      if (scramble) begin
        req_we     = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        resp_ready = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        resp_ready = 1'b0;
        lat        = n;
      end else begin
        @(posedge clk);
        n++;
      end
    end
    resp_ready = 1'b0;
    rd     = resp_rdata;
    err    = resp_err;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== err || req_ready !== 1'b0)
        stable = 1'b0;
      if (scramble) begin
        req_addr  = $urandom;
        req_wdata = $urandom;
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    rst = 1'b1;
  endtask

  task automatic test_preload;
    bit rdy, st; int lat; logic [31:0] rd, erd, wd; logic err, eerr;
    for (int i = 0; i < DEPTH; i++) begin
      wd = $urandom;
      model(1'b1, 32'(i) << 2, wd, erd, eerr);
      txn(1'b1, 32'(i) << 2, wd, 0, 1'b0, rdy, lat, rd, err, st);
      checks++; if (lat !== LATENCY || err !== eerr || rd !== erd)
        begin errors++; $display("FAIL preload_%0d: got lat=%0d err=%b rd=%h expected lat=%0d err=%b rd=%h", i, lat, err, rd, LATENCY, eerr, erd); end
    end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 8'(i);
      #1;
      checks++; if (dbg_data !== ref_mem[i]) begin errors++; $display("FAIL preload_dbg_%0d: got %h expected %h", i, dbg_data, ref_mem[i]); end
    end
  endtask

  task automatic test_basic;
    bit rdy, st; int lat; logic [31:0] rd, erd; logic err, eerr;
    model(1'b1, 32'h10, 32'hDEADBEEF, erd, eerr);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, rdy, lat, rd, err, st);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_st_ready: got %b expected 1", rdy); end
    checks++; if (lat !== LATENCY) begin errors++; $display("FAIL basic_st_latency: got %0d expected %0d", lat, LATENCY); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL basic_st_resp: got err=%b rd=%h expected err=0 rd=0", err, rd); end
    dbg_addr = 8'd4;
    #1;
    checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_dbg: got %h expected deadbeef", dbg_data); end
    model(1'b0, 32'h10, 32'h0, erd, eerr);
    txn(1'b0, 32'h10, 32'h0, 0, 1'b0, rdy, lat, rd, err, st);
    checks++; if (lat !== LATENCY) begin errors++; $display("FAIL basic_ld_latency: got %0d expected %0d", lat, LATENCY); end
    checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL basic_ld_resp: got err=%b rd=%h expected err=0 rd=deadbeef", err, rd); end
  endtask

  task automatic test_backpressure;
    bit rdy, st; int lat; logic [31:0] rd, erd, a; logic err, eerr;
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    model(1'b0, a, 32'h0, erd, eerr);
    txn(1'b0, a, 32'h0, 5, 1'b0, rdy, lat, rd, err, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL backpressure_stable: got %b expected 1", st); end
    checks++; if (rd !== erd || err !== eerr) begin errors++; $display("FAIL backpressure_resp: got err=%b rd=%h expected err=%b rd=%h", err, rd, eerr, erd); end
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL backpressure_release: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready); end
  endtask

  task automatic test_misaligned;
    bit rdy, st; int lat; logic [31:0] rd, erd; logic err, eerr;
    model(1'b1, 32'h13, 32'h1234, erd, eerr);
    txn(1'b1, 32'h13, 32'h1234, 0, 1'b0, rdy, lat, rd, err, st);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL misaligned_st_resp: got err=%b rd=%h expected err=1 rd=0", err, rd); end
    dbg_addr = 8'd4;
    #1;
    checks++; if (dbg_data !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned_st_mem: got %h expected deadbeef", dbg_data); end
    txn(1'b0, 32'h11, 32'h0, 1, 1'b0, rdy, lat, rd, err, st);
    checks++; if (err !== 1'b1 || rd !== 32'h0 || lat !== LATENCY)
      begin errors++; $display("FAIL misaligned_ld_resp: got err=%b rd=%h lat=%0d expected err=1 rd=0 lat=%0d", err, rd, lat, LATENCY); end
  endtask

  task automatic test_wrap;
    bit rdy, st; int lat; logic [31:0] rd, erd; logic err, eerr;
    model(1'b1, 32'h400, 32'hA5A5A5A5, erd, eerr);
    txn(1'b1, 32'h400, 32'hA5A5A5A5, 0, 1'b0, rdy, lat, rd, err, st);
    dbg_addr = 8'd0;
    #1;
    checks++; if (dbg_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_dbg: got %h expected a5a5a5a5", dbg_data); end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL reset_wait_state: got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dbg_addr = 8'd8;
    #1;
    checks++; if (dbg_data !== ref_mem[8]) begin errors++; $display("FAIL reset_wait_mem: got %h expected %h", dbg_data, ref_mem[8]); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_wait_no_resp: got %b expected 0", resp_valid); end
    // Reset while a load response is being held.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while (resp_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL reset_resp_reach: got %b expected 1", resp_valid); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    checks++; if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL reset_resp_discard: got valid=%b rd=%h err=%b ready=%b expected 0/0/0/1", resp_valid, resp_rdata, resp_err, req_ready); end
  endtask

  task automatic test_isolation;
    bit rdy, st; int lat; logic [31:0] rd, erd, a, wd; logic err, eerr;
    for (int k = 0; k < 6; k++) begin
      a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      wd = $urandom;
      model(1'(k % 2), a, wd, erd, eerr);
      txn(1'(k % 2), a, wd, 3, 1'b1, rdy, lat, rd, err, st);
      checks++; if (lat !== LATENCY || rd !== erd || err !== eerr || st !== 1'b1)
        begin errors++; $display("FAIL isolation_%0d: got lat=%0d rd=%h err=%b stable=%b expected lat=%0d rd=%h err=%b stable=1", k, lat, rd, err, st, LATENCY, erd, eerr); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
        begin errors++; $display("FAIL isolation_extra_%0d: got valid=%b ready=%b expected valid=0 ready=1", k, resp_valid, req_ready); end
      dbg_addr = a[9:2];
      #1;
      checks++; if (dbg_data !== ref_mem[widx(a)]) begin errors++; $display("FAIL isolation_mem_%0d: got %h expected %h", k, dbg_data, ref_mem[widx(a)]); end
    end
  endtask

  task automatic test_back_to_back;
    bit rdy, st; int lat; logic [31:0] rd, erd, a, wd; logic err, eerr;
    for (int k = 0; k < 8; k++) begin
      a  = $urandom & 32'hFFFF_FFFC;
      wd = $urandom;
      model(1'b1, a, wd, erd, eerr);
      txn(1'b1, a, wd, 0, 1'b0, rdy, lat, rd, err, st);
      model(1'b0, a, 32'h0, erd, eerr);
      txn(1'b0, a, 32'h0, 0, 1'b0, rdy, lat, rd, err, st);
      checks++; if (rdy !== 1'b1 || rd !== wd || err !== 1'b0 || lat !== LATENCY)
        begin errors++; $display("FAIL b2b_%0d: got rdy=%b rd=%h err=%b lat=%0d expected rdy=1 rd=%h err=0 lat=%0d", k, rdy, rd, err, lat, wd, LATENCY); end
    end
  endtask

  task automatic test_random;
    bit rdy, st, we; int lat, hold; logic [31:0] rd, erd, a, wd; logic err, eerr;
    for (int k = 0; k < 100; k++) begin
      we = 1'($urandom_range(0, 1));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      model(we, a, wd, erd, eerr);
      txn(we, a, wd, hold, 1'($urandom_range(0, 1)), rdy, lat, rd, err, st);
      checks++; if (rdy !== 1'b1 || lat !== LATENCY || rd !== erd || err !== eerr || st !== 1'b1)
        begin errors++; $display("FAIL random_%0d: got rdy=%b lat=%0d rd=%h err=%b stable=%b expected rdy=1 lat=%0d rd=%h err=%b stable=1", k, rdy, lat, rd, err, st, LATENCY, erd, eerr); end
      dbg_addr = 8'(widx(a));
      #1;
      checks++; if (dbg_data !== ref_mem[widx(a)]) begin errors++; $display("FAIL random_mem_%0d: got %h expected %h", k, dbg_data, ref_mem[widx(a)]); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic();
    test_backpressure();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_isolation();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, data/address width.
- ADDR_BITS, 8, word-index bits (memory depth 2^ADDR_BITS words).
- LATENCY, 2, edges from request acceptance to response; legal range 1..15.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  WIDTH  byte address; word index = req_addr[ADDR_BITS+1:2].
- req_wdata  in  WIDTH  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  WIDTH  load data (0 for stores and errors).
- resp_err  out  1  misaligned request (req_addr[1:0] != 0).
- dbg_addr  in  ADDR_BITS  debug word index.
- dbg_data  out  WIDTH  combinational read of mem[dbg_addr].

REQ-003 The clock and reset SHALL be one clock with synchronous active-low reset: clk and rst, with rst = 0 sampled at a rising edge resetting the block.

Function
REQ-004 The FSM SHALL have states IDLE, WAIT and RESP, with at most one transaction outstanding.
REQ-005 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-006 A request SHALL be accepted at an edge where state = IDLE and req_valid = 1, and acceptance SHALL have these effects:
- req_we, the word index, req_wdata and the misalignment flag captured;
- counter loaded with LATENCY-1;
- state set to WAIT.
REQ-007 In WAIT, each edge with counter != 0 SHALL decrement the counter.
REQ-008 In WAIT, an edge with counter = 0 SHALL perform the access and enter RESP, so resp_valid rises exactly LATENCY edges after the accepting edge.
REQ-009 The access for an aligned load SHALL set resp_rdata <= mem[idx] and resp_err <= 0.
REQ-010 The access for an aligned store SHALL set mem[idx] <= wdata, resp_rdata <= 0 and resp_err <= 0.
REQ-011 The access for a misaligned load or store SHALL leave memory unchanged and set resp_rdata <= 0 and resp_err <= 1.
REQ-012 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready = 1.
REQ-013 At the edge with resp_ready = 1, resp_valid SHALL be cleared and the state SHALL return to IDLE; a new request is acceptable no earlier than the following edge.
REQ-014 Address bits above ADDR_BITS+1 SHALL be ignored, so indices wrap modulo 2^ADDR_BITS.
REQ-015 req_valid, req_we, req_addr and req_wdata SHALL be ignored outside IDLE; changes to them after acceptance SHALL not affect the transaction.
REQ-016 resp_ready SHALL be ignored outside RESP.
REQ-017 A load issued after a completed store to the same word SHALL return the stored data.
REQ-018 dbg_data SHALL reflect memory contents combinationally, including writes completed at the previous edge.

Reset
REQ-019 With rst = 0 at an edge, the following SHALL hold after that edge:
- state = IDLE, counter = 0;
- req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-020 Reset SHALL NOT clear the memory array.
REQ-021 Reset during WAIT SHALL abandon the transaction, and a pending store SHALL NOT be written.
REQ-022 Reset during RESP SHALL discard the response.
REQ-023 Reset SHALL take priority over every other event at the same edge.

Verification
REQ-024 Basic store/load: LATENCY=2, store addr 0x10 data 0xDEADBEEF accepted at edge t, resp_ready held 1 -> resp_valid=1 after edge t+2, resp_err=0, resp_rdata=0; dbg_addr=4 -> dbg_data=0xDEADBEEF; then load 0x10 -> resp_rdata=0xDEADBEEF two edges after acceptance.
REQ-025 Backpressure: load response with resp_ready=0 for 5 cycles -> resp_valid, resp_rdata, resp_err stable and req_ready=0 throughout; resp_ready=1 -> resp_valid=0 and req_ready=1 after that edge.
REQ-026 Misaligned store: store addr 0x13 data 0x1234 -> resp_err=1, resp_rdata=0, mem[4] unchanged per dbg_data.
REQ-027 Wrap-around: ADDR_BITS=8, store addr 0x400 data 0xA5A5A5A5 -> dbg_addr=0 reads 0xA5A5A5A5.
REQ-028 Reset mid-store: store addr 0x20 data 0x55 accepted, rst=0 at the next edge (LATENCY=2) -> resp_valid=0, req_ready=1, mem[8] keeps its old value.
REQ-029 Input isolation: req_valid held 1 with changing req_addr/req_wdata during WAIT and RESP -> no extra accept, and the response matches the originally captured request.
